// File: rtl/coin_anim_addr_gen.sv
// rtl/coin_anim_addr_gen.sv - coin sprite ROM address, spin frame and pop life-cycle generator
//
// Maps the scan position onto a read address for the 20x20 coin-spin sprite
// ROMs, selects the spin frame, flags pixels inside the coin box and runs the
// coin life cycle IDLE -> SPIN -> POP (on collect) -> DONE.
//
// Ports:
//   Clk            in   system clock (pixel-rate domain)
//   Reset_n        in   asynchronous active-low reset
//   frame_clk      in   vsync-rate level, synchronous to Clk
//   DrawX, DrawY   in   current scan position
//   coin_x, coin_y in   coin top-left corner
//   coin_active    in   coin exists in the level
//   collect        in   one-cycle pulse when Mario touches the coin
//   read_address   out  sprite ROM address dy*SPRITE_W+dx, one Clk behind DrawX/DrawY
//   frame_sel      out  spin frame ROM select
//   pixel_valid    out  delayed pixel lies inside the coin box
//   collected_done out  pop animation finished
module coin_anim_addr_gen #(
    parameter int SPRITE_W        = 20,
    parameter int SPRITE_H        = 20,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAMES_PER_STEP = 8,
    parameter int POP_HEIGHT      = 32,
    parameter int POP_STEP        = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] coin_x,
    input  logic [9:0] coin_y,
    input  logic       coin_active,
    input  logic       collect,
    output logic [8:0] read_address,
    output logic [1:0] frame_sel,
    output logic       pixel_valid,
    output logic       collected_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SPIN = 2'd1;
    localparam logic [1:0] ST_POP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int POP_W  = $clog2(POP_HEIGHT + 1);

    localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [1:0]        FRAME_LAST   = 2'(NUM_FRAMES - 1);
    localparam logic [POP_W:0]    POP_STEP_C   = (POP_W + 1)'(POP_STEP);
    localparam logic [POP_W:0]    POP_HEIGHT_C = (POP_W + 1)'(POP_HEIGHT);
    localparam logic [10:0]       SPRITE_W_C   = 11'(SPRITE_W);
    localparam logic [10:0]       SPRITE_H_C   = 11'(SPRITE_H);

    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [1:0]        frame_sel_q, frame_sel_d;
    logic [POP_W-1:0]  pop_offset_q, pop_offset_d;
    logic              frame_clk_d_q, frame_clk_d_d;
    logic [8:0]        read_address_q, read_address_d;
    logic              pixel_valid_q, pixel_valid_d;

    logic              fe;
    logic              animating;
    logic [POP_W:0]    pop_sum;
    logic [10:0]       dx, dy;
    logic              in_box;
    logic [8:0]        addr;

    // A held-high frame_clk yields exactly one edge because frame_clk_d
    // follows it every Clk.
    assign fe        = frame_clk & ~frame_clk_d_q;
    assign animating = (state_q == ST_SPIN) || (state_q == ST_POP);
    assign pop_sum   = {1'b0, pop_offset_q} + POP_STEP_C;

    // 11-bit two's-complement offsets: bit 10 set means the pixel is left of /
    // above the box. The widest sum (1023 + POP_HEIGHT) also lands with bit 10
    // set, which is out of the box anyway, so no false hit can wrap around.
    assign dx = {1'b0, DrawX} - {1'b0, coin_x};
    assign dy = {1'b0, DrawY} + 11'(pop_offset_q) - {1'b0, coin_y};

    assign in_box = animating
                    && !dx[10] && (dx < SPRITE_W_C)
                    && !dy[10] && (dy < SPRITE_H_C);

    generate
        if (SPRITE_W == 20) begin : g_addr_shift
            assign addr = (dy[8:0] << 4) + (dy[8:0] << 2) + dx[8:0];
        end else begin : g_addr_mul
            assign addr = dy[8:0] * 9'(SPRITE_W) + dx[8:0];
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        frame_sel_d    = frame_sel_q;
        pop_offset_d   = pop_offset_q;
        frame_clk_d_d  = frame_clk;
        read_address_d = in_box ? addr : 9'd0;
        pixel_valid_d  = in_box;

        // Spin keeps running through the pop so the coin still turns as it rises.
        if (fe && animating) begin
            if (step_q == STEP_LAST) begin
                step_d      = '0;
                frame_sel_d = (frame_sel_q == FRAME_LAST) ? 2'd0 : frame_sel_q + 2'd1;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (coin_active) begin
                    state_d = ST_SPIN;
                end
            end
            ST_SPIN: begin
                // Coin removal wins over a simultaneous collect.
                if (!coin_active) begin
                    state_d = ST_IDLE;
                end else if (collect) begin
                    state_d = ST_POP;
                end
            end
            ST_POP: begin
                if (fe) begin
                    if (pop_sum >= POP_HEIGHT_C) begin
                        pop_offset_d = POP_W'(POP_HEIGHT);
                        state_d      = ST_DONE;
                    end else begin
                        pop_offset_d = pop_sum[POP_W-1:0];
                    end
                end
            end
            default: begin
                if (!coin_active) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // Entering (or sitting in) IDLE leaves the animation fully rewound,
        // overriding any edge that arrived in the same cycle.
        if (state_d == ST_IDLE) begin
            step_d       = '0;
            frame_sel_d  = 2'd0;
            pop_offset_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= ST_IDLE;
            step_q         <= '0;
            frame_sel_q    <= 2'd0;
            pop_offset_q   <= '0;
            frame_clk_d_q  <= 1'b0;
            read_address_q <= 9'd0;
            pixel_valid_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            frame_sel_q    <= frame_sel_d;
            pop_offset_q   <= pop_offset_d;
            frame_clk_d_q  <= frame_clk_d_d;
            read_address_q <= read_address_d;
            pixel_valid_q  <= pixel_valid_d;
        end
    end

    assign read_address   = read_address_q;
    assign frame_sel      = frame_sel_q;
    assign pixel_valid    = pixel_valid_q;
    assign collected_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_coin_anim_addr_gen.sv
// tb/tb_coin_anim_addr_gen.sv - self-checking bench for coin_anim_addr_gen
module tb_coin_anim_addr_gen;

    localparam int SW = 20;
    localparam int SH = 20;
    localparam int NF = 4;
    localparam int FPS = 8;
    localparam int PH = 32;
    localparam int PS = 2;

    localparam int M_IDLE = 0;
    localparam int M_SPIN = 1;
    localparam int M_POP  = 2;
    localparam int M_DONE = 3;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] coin_x = '0;
    logic [9:0] coin_y = '0;
    logic       coin_active = 1'b0;
    logic       collect = 1'b0;
    logic [8:0] read_address;
    logic [1:0] frame_sel;
    logic       pixel_valid;
    logic       collected_done;

    int n_vec = 0;
    int n_bad = 0;

    int m_mode = M_IDLE;
    int m_anim = 0;
    int m_pop  = 0;
    bit m_fprev = 1'b0;
    int e_addr = 0;
    bit e_valid = 1'b0;

    coin_anim_addr_gen dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_clk      (frame_clk),
        .DrawX          (DrawX),
        .DrawY          (DrawY),
        .coin_x         (coin_x),
        .coin_y         (coin_y),
        .coin_active    (coin_active),
        .collect        (collect),
        .read_address   (read_address),
        .frame_sel      (frame_sel),
        .pixel_valid    (pixel_valid),
        .collected_done (collected_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_anim  = 0;
        m_pop   = 0;
        m_fprev = 1'b0;
        e_addr  = 0;
        e_valid = 1'b0;
    endtask

    // Behavioural reference: spin frame is the number of animation edges
    // divided down, pop height is edges*step clamped at the top.
    task automatic model_edge();
        int dx;
        int dy;
        int nmode;
        bit fe;
        if (!Reset_n) begin
            model_reset();
            return;
        end
        fe = frame_clk && !m_fprev;
        dx = int'(DrawX) - int'(coin_x);
        dy = int'(DrawY) + m_pop - int'(coin_y);
        e_valid = ((m_mode == M_SPIN) || (m_mode == M_POP))
                  && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
        e_addr = e_valid ? dy * SW + dx : 0;
        nmode = m_mode;
        if (fe && ((m_mode == M_SPIN) || (m_mode == M_POP))) m_anim++;
        case (m_mode)
            M_IDLE: if (coin_active) nmode = M_SPIN;
            M_SPIN: begin
                if (!coin_active) nmode = M_IDLE;
                else if (collect) nmode = M_POP;
            end
            M_POP: begin
                if (fe) begin
                    if (m_pop + PS >= PH) nmode = M_DONE;
                    m_pop = (m_pop + PS > PH) ? PH : m_pop + PS;
                end
            end
            default: if (!coin_active) nmode = M_IDLE;
        endcase
        if (nmode == M_IDLE) begin
            m_pop  = 0;
            m_anim = 0;
        end
        m_mode  = nmode;
        m_fprev = frame_clk;
    endtask

    task automatic check_all();
        chk("read_address", 32'(read_address), 32'(e_addr));
        chk("pixel_valid", 32'(pixel_valid), 32'(e_valid));
        chk("frame_sel", 32'(frame_sel), 32'((m_anim / FPS) % NF));
        chk("collected_done", 32'(collected_done), 32'(m_mode == M_DONE));
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_all();
    endtask

    task automatic fe_pulse();
        frame_clk = 1'b1;
        cyc();
        frame_clk = 1'b0;
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) cyc();
        Reset_n = 1'b1;

        // Addressing
        coin_x = 10'd100; coin_y = 10'd200; coin_active = 1'b1;
        cyc();
        DrawX = 10'd105; DrawY = 10'd203; cyc();
        chk("addr_105_203", 32'(read_address), 32'd65);
        chk("valid_105_203", 32'(pixel_valid), 32'd1);
        DrawX = 10'd120; DrawY = 10'd200; cyc();
        chk("valid_120_200", 32'(pixel_valid), 32'd0);
        DrawX = 10'd119; DrawY = 10'd219; cyc();
        chk("addr_119_219", 32'(read_address), 32'd399);

        // Spin
        for (int i = 1; i <= 32; i++) begin
            fe_pulse();
            if (i % 8 == 0) chk("spin_frame", 32'(frame_sel), 32'((i / 8) % 4));
        end
        frame_clk = 1'b1;
        repeat (100) cyc();
        frame_clk = 1'b0;
        cyc();
        repeat (7) fe_pulse();
        chk("held_high_single_fe", 32'(frame_sel), 32'd1);

        // Pop
        collect = 1'b1; cyc(); collect = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            fe_pulse();
            if (k == 8) begin
                DrawX = 10'd100; DrawY = 10'd184; cyc();
                chk("pop_addr_100_184", 32'(read_address), 32'd0);
                chk("pop_valid_100_184", 32'(pixel_valid), 32'd1);
            end
            if (k == 15) chk("pop_not_done_15", 32'(collected_done), 32'd0);
        end
        chk("pop_done_16", 32'(collected_done), 32'd1);
        DrawX = 10'd100; DrawY = 10'd168; cyc();
        chk("done_valid", 32'(pixel_valid), 32'd0);
        coin_active = 1'b0; cyc();
        chk("done_to_idle", 32'(collected_done), 32'd0);

        // Async reset mid-pop
        coin_active = 1'b1; cyc();
        collect = 1'b1; cyc(); collect = 1'b0;
        repeat (3) fe_pulse();
        DrawX = 10'd100; DrawY = 10'd200; cyc();
        chk("midpop_addr", 32'(read_address), 32'd120);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_frame", 32'(frame_sel), 32'd0);
        chk("rst_done", 32'(collected_done), 32'd0);
        model_reset();
        cyc();
        Reset_n = 1'b1;
        cyc();
        DrawX = 10'd100; DrawY = 10'd200; cyc();
        chk("post_rst_pop_cleared", 32'(read_address), 32'd0);
        chk("post_rst_valid", 32'(pixel_valid), 32'd1);

        // Corners: collect in IDLE, collect with coin_active low
        coin_active = 1'b0; cyc();
        collect = 1'b1; cyc(); collect = 1'b0;
        cyc();
        chk("idle_collect_ignored", 32'(pixel_valid), 32'd0);
        coin_active = 1'b1; cyc();
        coin_active = 1'b0; collect = 1'b1; cyc(); collect = 1'b0;
        cyc();
        chk("collect_loses_to_inactive", 32'(pixel_valid), 32'd0);
        coin_active = 1'b1; cyc(); cyc();
        chk("respin_valid", 32'(pixel_valid), 32'd1);

        // coin_y=5 with the pop near the top: no wrap onto the bottom rows
        coin_y = 10'd5;
        collect = 1'b1; cyc(); collect = 1'b0;
        repeat (15) fe_pulse();
        for (int i = 0; i < 40; i++) begin
            DrawX = 10'(100 + i % 20);
            DrawY = (i < 20) ? 10'(1004 + i) : 10'(i - 20);
            cyc();
        end
        DrawX = 10'd100; DrawY = 10'd1023; cyc();
        chk("no_wrap_1023", 32'(pixel_valid), 32'd0);
        fe_pulse();
        chk("top_done", 32'(collected_done), 32'd1);

        // Randomized
        coin_x = 10'd300; coin_y = 10'd300;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                coin_x = 10'($urandom);
                coin_y = 10'($urandom);
            end
            if (coin_active) begin
                if ($urandom_range(0, 149) == 0) coin_active = 1'b0;
            end else begin
                if ($urandom_range(0, 9) == 0) coin_active = 1'b1;
            end
            collect = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 3) == 0) begin
                DrawX = 10'($urandom);
                DrawY = 10'($urandom);
            end else begin
                DrawX = 10'(int'(coin_x) + int'($urandom_range(0, 23)) - 2);
                DrawY = 10'(int'(coin_y) + int'($urandom_range(0, 56)) - 34);
            end
            cyc();
        end
        collect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
